// File: rtl/hpc3_rand_source_if.sv
// Randomness delivery bus between hpc3_rand_source and the masked-gadget consumers.
// One set of r and p elements is transferred on each out_valid && in_ready cycle.
interface hpc3_rand_source_if #(
    parameter int NUM_QUADRATIC = 3,
    parameter int BIT_WIDTH     = 1
);
    logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_r;
    logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_p;
    logic                                    out_valid;
    logic                                    in_ready;

    modport master (
        output out_r,
        output out_p,
        output out_valid,
        input  in_ready
    );

    modport slave (
        input  out_r,
        input  out_p,
        input  out_valid,
        output in_ready
    );
endinterface

// File: rtl/hpc3_rand_source.sv
// Fresh-randomness source for HPC3 multipliers: parallel xorshift32 lanes behind a
// seed-load / warm-up controller, presenting one r/p set per valid/ready handshake.
module hpc3_rand_source #(
    parameter int NUM_SHARES    = 3,
    parameter int BIT_WIDTH     = 1,
    parameter int WARMUP_CYCLES = 4
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic [31:0]        in_seed,
    input  logic               in_seed_valid,
    hpc3_rand_source_if.master rnd,
    output logic               out_seeded,
    output logic [31:0]        out_count
);
    localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int Q_BITS        = NUM_QUADRATIC * BIT_WIDTH;
    localparam int OUT_BITS      = 2 * Q_BITS;
    localparam int NUM_LANES     = (OUT_BITS + 31) / 32;
    localparam int LANE_BITS     = NUM_LANES * 32;
    localparam int CNT_W         = (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);
    localparam logic [31:0] GOLDEN = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    // A seed load skips warm-up entirely when no warm-up steps are configured.
    localparam state_t SEED_NEXT = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;

    function automatic logic [31:0] xs32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Zero is a fixed point of xorshift, so it is never allowed into a lane.
    function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int k);
        logic [31:0] v;
        v = seed ^ (32'(k) * GOLDEN);
        return (v == 32'h0) ? 32'h0000_0001 : v;
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic [LANE_BITS-1:0]   r_lanes;
    logic [LANE_BITS-1:0]   w_step_lanes;
    logic [LANE_BITS-1:0]   w_seed_lanes;
    logic [CNT_W-1:0]       r_warm;
    logic [31:0]            r_count;
    logic                   w_handshake;
    logic                   w_advance;

    always_comb begin
        w_step_lanes = '0;
        w_seed_lanes = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_step_lanes[k*32 +: 32] = xs32_step(r_lanes[k*32 +: 32]);
            w_seed_lanes[k*32 +: 32] = lane_seed(in_seed, k);
        end
    end

    assign w_handshake = (r_state == ST_RUN) && rnd.in_ready;
    assign w_advance   = (r_state == ST_WARMUP) || w_handshake;

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            r_lanes <= '0;
            r_warm  <= '0;
            r_count <= '0;
        end else if (in_seed_valid) begin
            r_lanes <= w_seed_lanes;
            r_warm  <= CNT_W'(WARMUP_CYCLES);
            r_count <= '0;
        end else begin
            if (w_advance) begin
                r_lanes <= w_step_lanes;
            end
            if (r_state == ST_WARMUP) begin
                r_warm <= r_warm - CNT_W'(1);
            end
            if (w_handshake && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            r_state <= ST_UNSEEDED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Warm-up ends on the step that takes the counter from 1 to 0.
    always_comb begin
        w_next_state = r_state;
        if (in_seed_valid) begin
            w_next_state = SEED_NEXT;
        end else begin
            case (r_state)
                ST_UNSEEDED: w_next_state = ST_UNSEEDED;
                ST_WARMUP:   w_next_state = (r_warm == CNT_W'(1)) ? ST_RUN : ST_WARMUP;
                ST_RUN:      w_next_state = ST_RUN;
                default:     w_next_state = ST_UNSEEDED;
            endcase
        end
    end

    always_comb begin
        rnd.out_valid = 1'b0;
        out_seeded    = 1'b0;
        if (r_state == ST_RUN) begin
            rnd.out_valid = 1'b1;
            out_seeded    = 1'b1;
        end
    end

    assign rnd.out_r = r_lanes[Q_BITS-1:0];
    assign rnd.out_p = r_lanes[OUT_BITS-1:Q_BITS];
    assign out_count = r_count;
endmodule

// File: tb/tb_hpc3_rand_source.sv
// Scoreboard bench for hpc3_rand_source: one instance without warm-up and one with
// four warm-up steps share the same seed/ready stimulus.
module tb_hpc3_rand_source;
    typedef struct packed {
        logic [2:0]  r;
        logic [2:0]  p;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seed;
    logic        seed_valid;
    logic        ready;
    logic        seeded0, seeded4;
    logic [31:0] count0, count4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int seed_cyc = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic        lat_pending [2];
    logic        armed       [2];
    logic        prev_hold   [2];
    logic [38:0] prev_vals   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hpc3_rand_source_if #(.NUM_QUADRATIC(3), .BIT_WIDTH(1)) if0 ();
    hpc3_rand_source_if #(.NUM_QUADRATIC(3), .BIT_WIDTH(1)) if4 ();

    assign if0.in_ready = ready;
    assign if4.in_ready = ready;

    hpc3_rand_source #(.NUM_SHARES(3), .BIT_WIDTH(1), .WARMUP_CYCLES(0)) dut0 (
        .in_clock      (clk),
        .in_reset      (rst_n),
        .in_seed       (seed),
        .in_seed_valid (seed_valid),
        .rnd           (if0),
        .out_seeded    (seeded0),
        .out_count     (count0)
    );

    hpc3_rand_source #(.NUM_SHARES(3), .BIT_WIDTH(1), .WARMUP_CYCLES(4)) dut4 (
        .in_clock      (clk),
        .in_reset      (rst_n),
        .in_seed       (seed),
        .in_seed_valid (seed_valid),
        .rnd           (if4),
        .out_seeded    (seeded4),
        .out_count     (count4)
    );

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    function automatic logic [31:0] xs(input logic [31:0] x);
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut=%0d actual=%0h required=%0h", name, d, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the delivered sets after a seed are the xorshift32 orbit of the
    // (non-zero) seed, skipping the warm-up steps, numbered from 0.
    task automatic do_seed(input logic [31:0] s);
        logic [31:0] st;
        exp_t        e;
        seed       = s;
        seed_valid = 1'b1;
        seed_cyc   = cyc;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            st = (s == 32'h0) ? 32'h1 : s;
            for (int i = 0; i < wc(d); i++) st = xs(st);
            for (int k = 0; k < 256; k++) begin
                e.r = st[2:0];
                e.p = st[5:3];
                e.c = k;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
                st = xs(st);
            end
            lat_pending[d] = 1'b1;
            armed[d]       = 1'b1;
        end
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            lat_pending[d] = 1'b0;
            armed[d]       = 1'b0;
        end
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic idle_check();
        chk("idle_valid",  0, 64'(if0.out_valid), 64'd0);
        chk("idle_seeded", 0, 64'(seeded0),       64'd0);
        chk("idle_count",  0, 64'(count0),        64'd0);
        chk("idle_rp",     0, 64'({if0.out_r, if0.out_p}), 64'd0);
        chk("idle_valid",  1, 64'(if4.out_valid), 64'd0);
        chk("idle_seeded", 1, 64'(seeded4),       64'd0);
        chk("idle_count",  1, 64'(count4),        64'd0);
        chk("idle_rp",     1, 64'({if4.out_r, if4.out_p}), 64'd0);
    endtask

    task automatic run_random(input int n, input int pct);
        repeat (n) begin
            ready = ($urandom_range(0, 99) < pct);
            tick();
        end
    endtask

    task automatic mon(input int d, input logic v, input logic s, input logic [2:0] r,
                       input logic [2:0] p, input logic [31:0] c);
        exp_t e;
        logic have;
        int   n;
        if (!rst_n) begin
            prev_hold[d] = 1'b0;
            return;
        end
        if (prev_hold[d]) chk("hold_stable", d, 64'({v, r, p, c}), 64'(prev_vals[d]));
        chk("seeded_eq_valid", d, 64'(s), 64'(v));
        if (seed_valid) begin
            prev_hold[d] = 1'b0;
            return;
        end
        n = cyc - seed_cyc;
        if (lat_pending[d]) begin
            if (v) begin
                chk("valid_latency", d, 64'(n), 64'(wc(d) + 1));
                lat_pending[d] = 1'b0;
            end else if (n > wc(d) + 3) begin
                checks++;
                failures++;
                $display("FAIL valid_timeout dut=%0d actual=no_valid_after_%0d required=%0d", d, n, wc(d) + 1);
                lat_pending[d] = 1'b0;
            end
        end else if (!armed[d]) begin
            chk("valid_unseeded", d, 64'(v), 64'd0);
        end
        if (v && ready) begin
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
            if (d == 1 && q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL unexpected_set dut=%0d actual=r%0h_p%0h required=none", d, r, p);
            end else begin
                chk("set_r",     d, 64'(r), 64'(e.r));
                chk("set_p",     d, 64'(p), 64'(e.p));
                chk("set_count", d, 64'(c), 64'(e.c));
            end
        end
        prev_hold[d] = v && !ready;
        prev_vals[d] = {v, r, p, c};
    endtask

    always @(negedge clk) begin
        mon(0, if0.out_valid, seeded0, if0.out_r, if0.out_p, count0);
        mon(1, if4.out_valid, seeded4, if4.out_r, if4.out_p, count4);
    end

    initial begin
        rst_n      = 1'b0;
        seed       = 32'h0;
        seed_valid = 1'b0;
        ready      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            lat_pending[d] = 1'b0;
            armed[d]       = 1'b0;
            prev_hold[d]   = 1'b0;
            prev_vals[d]   = '0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        idle_check();
        repeat (8) tick();
        idle_check();

        ready = 1'b1;
        do_seed(32'h0000_0001);
        repeat (12) tick();
        do_seed(32'h0000_0000);
        repeat (12) tick();

        ready = 1'b0;
        repeat (10) tick();
        ready = 1'b1;
        repeat (3) tick();

        ready = 1'b1;
        do_seed($urandom);
        run_random(30, 60);

        do_seed($urandom);
        repeat (2) tick();
        do_reset(1);
        idle_check();
        ready = 1'b1;
        do_seed(32'h0000_0001);
        run_random(15, 70);

        repeat (6) begin
            do_seed($urandom);
            run_random($urandom_range(5, 40), $urandom_range(20, 100));
        end
        ready = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
